// File: rtl/hazard_scoreboard.sv
// ID-stage RAW hazard scoreboard: per-register cycles-until-available counters.
// Ports: clock/reset, ID instruction fields in, pc_load/if_id_load/bubble/hazard/stall_count out.
module hazard_scoreboard #(
  parameter int ADDR_W   = 5,
  parameter int CNT_W    = 2,
  parameter int ALU_LAT  = 0,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic              rs1_used,
  input  logic              rs2_used,
  input  logic [ADDR_W-1:0] rd,
  input  logic              rd_write,
  input  logic              is_load,
  input  logic              flush,
  output logic              pc_load,
  output logic              if_id_load,
  output logic              bubble,
  output logic              hazard,
  output logic [PERF_W-1:0] stall_count
);

  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_LAT);
  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_LAT);

  // x0 has no storage; its read view is a constant zero.
  logic [NUM_REGS-1:1][CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0]               cnt_rd [NUM_REGS];

  logic hz1;
  logic hz2;
  logic issue;
  logic wr_en;

  always_comb begin
    cnt_rd[0] = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      cnt_rd[r] = cnt_q[r];
    end
  end

  always_comb begin
    hz1    = rs1_used && (rs1 != '0) && (cnt_rd[rs1] != '0);
    hz2    = rs2_used && (rs2 != '0) && (cnt_rd[rs2] != '0);
    hazard = !reset && issue_valid && (hz1 || hz2);
    issue  = issue_valid && !hazard && !flush && !reset;
    wr_en  = issue && rd_write && (rd != '0);
  end

  // Priority: reset, then flush, then hazard.
  always_comb begin
    pc_load    = 1'b1;
    if_id_load = 1'b1;
    bubble     = 1'b0;
    if (reset) begin
      pc_load    = 1'b0;
      if_id_load = 1'b0;
      bubble     = 1'b1;
    end else if (flush) begin
      bubble     = 1'b1;
    end else if (hazard) begin
      pc_load    = 1'b0;
      if_id_load = 1'b0;
      bubble     = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q       <= '0;
      stall_count <= '0;
    end else begin
      for (int r = 1; r < NUM_REGS; r++) begin
        if (wr_en && (rd == ADDR_W'(r))) begin
          cnt_q[r] <= is_load ? LOAD_CNT : ALU_CNT;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - 1'b1;
        end
      end
      if (hazard && !flush && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule
